// File: rtl/arbitro_memoria_original.sv
// arbitro_memoria_original
// Single-port arbiter for the original-image RAM (160x120x8 buffer).
// One memory port is shared by the VGA idle-display reader, the resize reader and
// the HPS pixel writer. VGA has strict priority; the HPS write and the resize read
// are served round-robin when both are waiting. Read data returns through a tagged
// pipe that tracks the memory latency, so several reads may be in flight at once.
module arbitro_memoria_original #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    // VGA idle-display reader (highest priority, one read per cycle)
    input  logic              vga_rd_en,
    input  logic [ADDR_W-1:0] vga_rd_addr,
    output logic              vga_rd_valid,
    output logic [DATA_W-1:0] vga_rd_data,
    // resize engine reader
    input  logic              redim_rd_req,
    input  logic [ADDR_W-1:0] redim_rd_addr,
    output logic              redim_rd_gnt,
    output logic              redim_rd_valid,
    output logic [DATA_W-1:0] redim_rd_data,
    // HPS pixel writer (four-phase handshake)
    input  logic              hps_wr_req,
    input  logic [ADDR_W-1:0] hps_wr_addr,
    input  logic [DATA_W-1:0] hps_wr_data,
    output logic              hps_wr_done,
    // memory port
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata,
    // sticky starvation flag
    output logic              starve_err
);

    // Wait counters must be able to hold MAX_WAIT+1, where they saturate.
    localparam int              CNT_W   = $clog2(MAX_WAIT + 2);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Source tags carried alongside each read through the latency pipe.
    localparam logic [1:0] TAG_NONE  = 2'd0;
    localparam logic [1:0] TAG_VGA   = 2'd1;
    localparam logic [1:0] TAG_REDIM = 2'd2;

    // Which low-priority requester won the last contested grant.
    localparam logic SRC_REDIM = 1'b0;
    localparam logic SRC_HPS   = 1'b1;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_PEND    = 2'd1,
        W_DONE    = 2'd2,
        W_WAITLOW = 2'd3
    } wr_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    wr_state_t         wr_state_q;
    logic              hps_done_q;
    logic              last_served_q;
    logic              last_served_d;
    logic [CNT_W-1:0]  hps_cnt_q;
    logic [CNT_W-1:0]  hps_cnt_d;
    logic [CNT_W-1:0]  redim_cnt_q;
    logic [CNT_W-1:0]  redim_cnt_d;
    logic              starve_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_wren_q;
    logic [1:0]        tag_q [0:RD_LAT];
    logic [1:0]        tag_d;
    logic              vga_valid_q;
    logic [DATA_W-1:0] vga_data_q;
    logic              redim_valid_q;
    logic [DATA_W-1:0] redim_data_q;

    // Combinational grant decisions for the coming edge
    logic              hps_pend_s;
    logic              gnt_vga_s;
    logic              gnt_hps_s;
    logic              gnt_redim_s;

    assign hps_pend_s = (wr_state_q == W_PEND);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------

    // Pick at most one requester for the next edge; nothing is taken during reset.
    always_comb begin
        gnt_vga_s     = 1'b0;
        gnt_hps_s     = 1'b0;
        gnt_redim_s   = 1'b0;
        last_served_d = last_served_q;
        if (rst) begin
            last_served_d = SRC_REDIM;
        end else if (vga_rd_en) begin
            gnt_vga_s = 1'b1;
        end else if (hps_pend_s && redim_rd_req) begin
            // Contested: the one not served last time wins.
            if (last_served_q == SRC_REDIM) begin
                gnt_hps_s     = 1'b1;
                last_served_d = SRC_HPS;
            end else begin
                gnt_redim_s   = 1'b1;
                last_served_d = SRC_REDIM;
            end
        end else if (hps_pend_s) begin
            gnt_hps_s = 1'b1;
        end else if (redim_rd_req) begin
            gnt_redim_s = 1'b1;
        end else begin
            gnt_vga_s = 1'b0;
        end
    end

    // Tag that enters the read-return pipe for the current grant.
    always_comb begin
        if (gnt_vga_s) begin
            tag_d = TAG_VGA;
        end else if (gnt_redim_s) begin
            tag_d = TAG_REDIM;
        end else begin
            tag_d = TAG_NONE;
        end
    end

    // Saturating wait counters: count unserved pending cycles, clear on grant or idle.
    always_comb begin
        if (!hps_pend_s || gnt_hps_s) begin
            hps_cnt_d = {CNT_W{1'b0}};
        end else if (hps_cnt_q == CNT_SAT) begin
            hps_cnt_d = hps_cnt_q;
        end else begin
            hps_cnt_d = hps_cnt_q + CNT_ONE;
        end

        if (!redim_rd_req || gnt_redim_s) begin
            redim_cnt_d = {CNT_W{1'b0}};
        end else if (redim_cnt_q == CNT_SAT) begin
            redim_cnt_d = redim_cnt_q;
        end else begin
            redim_cnt_d = redim_cnt_q + CNT_ONE;
        end
    end

    // Round-robin pointer, wait counters and the sticky starvation flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_served_q <= SRC_REDIM;
            hps_cnt_q     <= {CNT_W{1'b0}};
            redim_cnt_q   <= {CNT_W{1'b0}};
            starve_q      <= 1'b0;
        end else begin
            last_served_q <= last_served_d;
            hps_cnt_q     <= hps_cnt_d;
            redim_cnt_q   <= redim_cnt_d;
            starve_q      <= starve_q | (hps_cnt_d == CNT_SAT) | (redim_cnt_d == CNT_SAT);
        end
    end

    // ------------------------------------------------------------------
    // Memory port
    // ------------------------------------------------------------------

    // Register the granted address/data; the address holds when nobody is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            mem_wren_q  <= 1'b0;
        end else begin
            mem_wren_q <= gnt_hps_s;
            if (gnt_vga_s) begin
                mem_addr_q <= vga_rd_addr;
            end else if (gnt_hps_s) begin
                mem_addr_q  <= hps_wr_addr;
                mem_wdata_q <= hps_wr_data;
            end else if (gnt_redim_s) begin
                mem_addr_q <= redim_rd_addr;
            end else begin
                mem_addr_q <= mem_addr_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read return path
    // ------------------------------------------------------------------

    // Tag pipe: entry 0 matches the registered address, entry RD_LAT matches mem_rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_q[i] <= TAG_NONE;
            end
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Route returning data to its requester; data holds between valids.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_valid_q   <= 1'b0;
            vga_data_q    <= {DATA_W{1'b0}};
            redim_valid_q <= 1'b0;
            redim_data_q  <= {DATA_W{1'b0}};
        end else begin
            vga_valid_q   <= (tag_q[RD_LAT] == TAG_VGA);
            redim_valid_q <= (tag_q[RD_LAT] == TAG_REDIM);
            if (tag_q[RD_LAT] == TAG_VGA) begin
                vga_data_q <= mem_rdata;
            end else if (tag_q[RD_LAT] == TAG_REDIM) begin
                redim_data_q <= mem_rdata;
            end else begin
                vga_data_q <= vga_data_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // HPS write handshake
    // ------------------------------------------------------------------

    // Write FSM: accept a request, wait for the grant, pulse done, then wait for req low
    // so a request held high never produces a second write.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            hps_done_q <= 1'b0;
        end else begin
            hps_done_q <= (wr_state_q == W_DONE);
            case (wr_state_q)
                W_IDLE: begin
                    if (hps_wr_req) begin
                        wr_state_q <= W_PEND;
                    end else begin
                        wr_state_q <= W_IDLE;
                    end
                end
                W_PEND: begin
                    if (gnt_hps_s) begin
                        wr_state_q <= W_DONE;
                    end else begin
                        wr_state_q <= W_PEND;
                    end
                end
                W_DONE: begin
                    wr_state_q <= W_WAITLOW;
                end
                W_WAITLOW: begin
                    if (!hps_wr_req) begin
                        wr_state_q <= W_IDLE;
                    end else begin
                        wr_state_q <= W_WAITLOW;
                    end
                end
                default: begin
                    wr_state_q <= W_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign redim_rd_gnt   = gnt_redim_s;
    assign vga_rd_valid   = vga_valid_q;
    assign vga_rd_data    = vga_data_q;
    assign redim_rd_valid = redim_valid_q;
    assign redim_rd_data  = redim_data_q;
    assign hps_wr_done    = hps_done_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_wren       = mem_wren_q;
    assign starve_err     = starve_q;

endmodule

// File: tb/tb_arbitro_memoria_original.sv
// Testbench for arbitro_memoria_original: directed scenarios plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_arbitro_memoria_original;

    localparam int ADDR_W   = 15;
    localparam int DATA_W   = 8;
    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 1023;
    localparam int MEM_SZ   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              vga_rd_en;
    logic [ADDR_W-1:0] vga_rd_addr;
    logic              vga_rd_valid;
    logic [DATA_W-1:0] vga_rd_data;
    logic              redim_rd_req;
    logic [ADDR_W-1:0] redim_rd_addr;
    logic              redim_rd_gnt;
    logic              redim_rd_valid;
    logic [DATA_W-1:0] redim_rd_data;
    logic              hps_wr_req;
    logic [ADDR_W-1:0] hps_wr_addr;
    logic [DATA_W-1:0] hps_wr_data;
    logic              hps_wr_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_rdata;
    logic              starve_err;

    always #5 clk = ~clk;

    arbitro_memoria_original #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .rst(rst),
        .vga_rd_en(vga_rd_en), .vga_rd_addr(vga_rd_addr),
        .vga_rd_valid(vga_rd_valid), .vga_rd_data(vga_rd_data),
        .redim_rd_req(redim_rd_req), .redim_rd_addr(redim_rd_addr),
        .redim_rd_gnt(redim_rd_gnt), .redim_rd_valid(redim_rd_valid),
        .redim_rd_data(redim_rd_data),
        .hps_wr_req(hps_wr_req), .hps_wr_addr(hps_wr_addr), .hps_wr_data(hps_wr_data),
        .hps_wr_done(hps_wr_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_rdata(mem_rdata), .starve_err(starve_err)
    );

    // Pipelined RAM with RD_LAT cycles from registered address to data
    logic [DATA_W-1:0] ram      [MEM_SZ];
    logic [DATA_W-1:0] rd_stage [RD_LAT];

    always @(posedge clk) begin
        rd_stage[0] <= ram[mem_addr];
        for (int i = 1; i < RD_LAT; i++) rd_stage[i] <= rd_stage[i-1];
        if (mem_wren) ram[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = rd_stage[RD_LAT-1];

    // ---------------- reference model ----------------
    typedef struct {
        bit                is_vga;
        int                due;
        logic [DATA_W-1:0] data;
    } ret_t;

    ret_t              ret_q[$];
    logic [DATA_W-1:0] ref_mem [MEM_SZ];
    int                cyc = 0;
    bit                m_hps_pend, m_hps_blk, m_last_hps, m_starve, m_wren, last_gr;
    int                m_free_edge, m_done_edge, m_cnt_h, m_cnt_r;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_vga_data, m_redim_data;
    bit                m_vga_valid, m_redim_valid, m_was_rst;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        ret_q.delete();
        m_hps_pend = 0; m_hps_blk = 0; m_last_hps = 0; m_starve = 0; m_wren = 0;
        m_free_edge = 0; m_done_edge = -10; m_cnt_h = 0; m_cnt_r = 0;
        m_addr = '0; m_wdata = '0; m_vga_data = '0; m_redim_data = '0;
        m_vga_valid = 0; m_redim_valid = 0;
    endtask

    // One clock: inputs are already set (at negedge); predict, clock, then compare.
    task automatic step();
        bit g_v, g_h, g_r, hp, rq;
        #1;
        hp = m_hps_pend;
        rq = redim_rd_req;
        g_v = 0; g_h = 0; g_r = 0;
        if (!rst) begin
            if (vga_rd_en) g_v = 1;
            else if (hp && rq) begin
                if (m_last_hps) g_r = 1; else g_h = 1;
                m_last_hps = g_h;
            end
            else if (hp) g_h = 1;
            else if (rq) g_r = 1;
        end
        chk("redim_gnt", 32'(redim_rd_gnt), 32'(g_r));
        last_gr = g_r;
        @(posedge clk);
        cyc++;
        m_was_rst = rst;
        if (rst) begin
            model_reset();
        end else begin
            m_wren = g_h;
            if (g_v) begin
                m_addr = vga_rd_addr;
                ret_q.push_back('{1'b1, cyc + RD_LAT + 1, ref_mem[vga_rd_addr]});
            end else if (g_h) begin
                m_addr  = hps_wr_addr;
                m_wdata = hps_wr_data;
                ref_mem[hps_wr_addr] = hps_wr_data;
                m_done_edge = cyc + 1;
            end else if (g_r) begin
                m_addr = redim_rd_addr;
                ret_q.push_back('{1'b0, cyc + RD_LAT + 1, ref_mem[redim_rd_addr]});
            end
            // starvation bookkeeping
            if (!hp || g_h) m_cnt_h = 0; else if (m_cnt_h < MAX_WAIT + 1) m_cnt_h++;
            if (!rq || g_r) m_cnt_r = 0; else if (m_cnt_r < MAX_WAIT + 1) m_cnt_r++;
            if (m_cnt_h == MAX_WAIT + 1 || m_cnt_r == MAX_WAIT + 1) m_starve = 1;
            // handshake: one write per request, re-armed only after req seen low
            if (g_h) begin
                m_hps_pend = 0; m_hps_blk = 1; m_free_edge = cyc + 2;
            end else if (m_hps_blk) begin
                if (cyc >= m_free_edge && !hps_wr_req) m_hps_blk = 0;
            end else if (!m_hps_pend && hps_wr_req) begin
                m_hps_pend = 1;
            end
            m_vga_valid = 0; m_redim_valid = 0;
            if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
                if (ret_q[0].is_vga) begin m_vga_valid = 1; m_vga_data = ret_q[0].data; end
                else begin m_redim_valid = 1; m_redim_data = ret_q[0].data; end
                void'(ret_q.pop_front());
            end
        end
        #1;
        chk("mem_wren",    32'(mem_wren),       32'(m_wren));
        chk("mem_addr",    32'(mem_addr),       32'(m_addr));
        if (m_wren || m_was_rst) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        chk("hps_done",    32'(hps_wr_done),    32'(cyc == m_done_edge && !m_was_rst));
        chk("vga_valid",   32'(vga_rd_valid),   32'(m_vga_valid));
        chk("vga_data",    32'(vga_rd_data),    32'(m_vga_data));
        chk("redim_valid", 32'(redim_rd_valid), 32'(m_redim_valid));
        chk("redim_data",  32'(redim_rd_data),  32'(m_redim_data));
        chk("starve_err",  32'(starve_err),     32'(m_starve));
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        vga_rd_en = 0; redim_rd_req = 0; hps_wr_req = 0;
    endtask

    initial begin
        for (int i = 0; i < MEM_SZ; i++) begin
            ram[i]     = 8'(i ^ (i >> 8));
            ref_mem[i] = 8'(i ^ (i >> 8));
        end
        for (int i = 0; i < RD_LAT; i++) rd_stage[i] = '0;
        rst = 1; idle_inputs();
        vga_rd_addr = '0; redim_rd_addr = '0; hps_wr_addr = '0; hps_wr_data = '0;
        model_reset();
        @(negedge clk);

        // reset: all outputs must be zero
        step(); step();
        rst = 0;
        chk("rst_vga_valid", 32'(vga_rd_valid), 32'd0);
        chk("rst_mem_addr",  32'(mem_addr),     32'd0);

        // VGA reads of addresses 0,1,2 on consecutive edges
        for (int a = 0; a < 3; a++) begin
            vga_rd_en = 1; vga_rd_addr = 15'(a); step();
        end
        vga_rd_en = 0;
        for (int i = 0; i < 5; i++) step();
        chk("vga_last_data", 32'(vga_rd_data), 32'h02);

        // single HPS write held high: exactly one write and one done
        hps_wr_req = 1; hps_wr_addr = 15'h1234; hps_wr_data = 8'hA5;
        for (int i = 0; i < 8; i++) step();
        hps_wr_req = 0;
        for (int i = 0; i < 3; i++) step();

        // write 0x3C to addr 5, then resize read of addr 5 right after
        hps_wr_req = 1; hps_wr_addr = 15'd5; hps_wr_data = 8'h3C;
        step();
        redim_rd_req = 1; redim_rd_addr = 15'd5;
        step(); step();
        redim_rd_req = 0; hps_wr_req = 0;
        for (int i = 0; i < 6; i++) step();
        chk("raw_data", 32'(redim_rd_data), 32'h3C);

        // contested HPS / resize after reset: HPS goes first
        rst = 1; step(); rst = 0;
        hps_wr_req = 1; hps_wr_addr = 15'd9; hps_wr_data = 8'h77; step();
        redim_rd_req = 1; redim_rd_addr = 15'd9;
        for (int i = 0; i < 4; i++) step();
        hps_wr_req = 0; redim_rd_req = 0;
        for (int i = 0; i < 6; i++) step();

        // VGA starves resize: starve_err sets and stays set
        rst = 1; step(); rst = 0;
        vga_rd_en = 1; redim_rd_req = 1; redim_rd_addr = 15'd3;
        for (int i = 0; i < 2000; i++) begin
            vga_rd_addr = 15'($urandom_range(0, MEM_SZ - 1));
            step();
        end
        vga_rd_en = 0;
        step();
        redim_rd_req = 0;
        for (int i = 0; i < 5; i++) step();
        chk("starve_sticky", 32'(starve_err), 32'd1);

        // two resize grants then reset: no return after reset
        rst = 1; step(); rst = 0;
        redim_rd_req = 1; redim_rd_addr = 15'd1; step();
        redim_rd_addr = 15'd2; step();
        redim_rd_req = 0; rst = 1; step(); rst = 0;
        for (int i = 0; i < 6; i++) step();
        chk("rst_redim_valid", 32'(redim_rd_valid), 32'd0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            vga_rd_en   = ($urandom_range(0, 3) == 0);
            vga_rd_addr = 15'($urandom_range(0, 15));
            if (!redim_rd_req || last_gr) begin
                redim_rd_req  = ($urandom_range(0, 2) == 0);
                redim_rd_addr = 15'($urandom_range(0, 15));
            end
            if (!hps_wr_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    hps_wr_req  = 1;
                    hps_wr_addr = 15'($urandom_range(0, 15));
                    hps_wr_data = 8'($urandom);
                end
            end else if (m_hps_blk && cyc >= m_done_edge && $urandom_range(0, 2) == 0) begin
                hps_wr_req = 0;
            end
            step();
        end
        rst = 0; idle_inputs();
        for (int i = 0; i < 8; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
